// File: rtl/fifo_reader.sv
// Read-side controller for the sample FIFO: drains fixed-size bursts on half-full and presents
// them as 16-bit words with a write strobe toward the FX3 slave-FIFO interface.
module fifo_reader #(
   parameter int unsigned BURST_WORDS = 2048,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic        outputClock,
   input  logic        nReset,
   input  logic        nReady,
   input  logic [9:0]  fifoData,
   input  logic        halfFull_flag,
   input  logic        full_flag,
   input  logic        usbReady,
   output logic        outputAck,
   output logic [15:0] usbData,
   output logic        usbWrite,
   output logic        overflow_flag,
   output logic [15:0] burstCount
);

   localparam int unsigned WordCntW = 12;
   localparam int unsigned GapCntW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [WordCntW-1:0] WordLast = WordCntW'(BURST_WORDS - 1);
   localparam logic [GapCntW-1:0]  GapLast  = GapCntW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBurst, StGap, StOverflow} state_e;

   state_e              state_q, state_d;
   logic [WordCntW-1:0] word_cnt_q, word_cnt_d;
   logic [GapCntW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [15:0]         usb_data_q, usb_data_d;
   logic                usb_write_q, usb_write_d;
   logic                overflow_q, overflow_d;
   logic [15:0]         burst_cnt_q, burst_cnt_d;

   always_comb begin
      state_d     = state_q;
      word_cnt_d  = word_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      usb_data_d  = usb_data_q;
      usb_write_d = 1'b0;
      overflow_d  = overflow_q;
      burst_cnt_d = burst_cnt_q;

      // The word acked in a BURST cycle is written on the following cycle, even on overflow.
      if (state_q == StBurst) begin
         usb_data_d  = {6'b0, fifoData};
         usb_write_d = 1'b1;
      end

      if (nReady) begin
         state_d     = StIdle;
         word_cnt_d  = '0;
         gap_cnt_d   = '0;
         usb_data_d  = usb_data_q;
         usb_write_d = 1'b0;
         overflow_d  = 1'b0;
      end else if (full_flag) begin
         state_d    = StOverflow;
         overflow_d = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (halfFull_flag && usbReady) begin
                  state_d    = StBurst;
                  word_cnt_d = '0;
               end
            end
            StBurst: begin
               if (word_cnt_q == WordLast) begin
                  state_d     = StGap;
                  gap_cnt_d   = '0;
                  burst_cnt_d = burst_cnt_q + 16'd1;
               end else begin
                  word_cnt_d = word_cnt_q + WordCntW'(1);
               end
            end
            StGap: begin
               if (gap_cnt_q == GapLast) begin
                  state_d = StIdle;
               end else begin
                  gap_cnt_d = gap_cnt_q + GapCntW'(1);
               end
            end
            StOverflow: begin
               state_d = StOverflow;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge outputClock) begin
      if (!nReset) begin
         state_q     <= StIdle;
         word_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         usb_data_q  <= '0;
         usb_write_q <= 1'b0;
         overflow_q  <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         word_cnt_q  <= word_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         usb_data_q  <= usb_data_d;
         usb_write_q <= usb_write_d;
         overflow_q  <= overflow_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign outputAck     = (state_q == StBurst);
   assign usbData       = usb_data_q;
   assign usbWrite      = usb_write_q;
   assign overflow_flag = overflow_q;
   assign burstCount    = burst_cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed and random stimulus for fifo_reader, checked cycle by cycle against a burst-level
// model (words left in burst, gap cycles left, overflow latch, pending write).
module tb_fifo_reader;

   localparam int BW = 8;
   localparam int GC = 4;

   logic        clk = 1'b0;
   logic        nReset, nReady, halfFull, full, usbReady;
   logic [9:0]  fifoData;
   logic        ack, usbWrite, ovf;
   logic [15:0] usbData, burstCount;

   int n_assert = 0;
   int n_fail   = 0;

   int          m_left, m_gap;
   logic        m_ovf, m_write;
   logic [15:0] m_data, m_bursts;

   int          cyc = 0;
   int          n_ack, n_wr;
   logic        ack_prev = 1'b0;
   int          ack_starts[$];
   logic [15:0] wr_data[$];
   logic [15:0] save_b;

   always #5 clk = ~clk;

   fifo_reader #(
      .BURST_WORDS(BW),
      .GAP_CYCLES (GC)
   ) dut (
      .outputClock  (clk),
      .nReset       (nReset),
      .nReady       (nReady),
      .fifoData     (fifoData),
      .halfFull_flag(halfFull),
      .full_flag    (full),
      .usbReady     (usbReady),
      .outputAck    (ack),
      .usbData      (usbData),
      .usbWrite     (usbWrite),
      .overflow_flag(ovf),
      .burstCount   (burstCount)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare outputs.
   task automatic step();
      logic        nw;
      logic [15:0] nd;
      @(posedge clk);
      cyc++;
      nw = (m_left > 0);
      nd = nw ? {6'b0, fifoData} : m_data;
      if (!nReset) begin
         m_left = 0; m_gap = 0; m_ovf = 1'b0; m_write = 1'b0; m_data = '0; m_bursts = '0;
      end else if (nReady) begin
         m_left = 0; m_gap = 0; m_ovf = 1'b0; m_write = 1'b0;
      end else begin
         m_write = nw;
         m_data  = nd;
         if (full) begin
            m_left = 0; m_gap = 0; m_ovf = 1'b1;
         end else if (!m_ovf) begin
            if (m_left > 0) begin
               m_left--;
               if (m_left == 0) begin
                  m_bursts = m_bursts + 16'd1;
                  m_gap    = GC;
               end
            end else if (m_gap > 0) begin
               m_gap--;
            end else if (halfFull && usbReady) begin
               m_left = BW;
            end
         end
      end
      #1;
      check("ack", 16'(ack), 16'(m_left > 0));
      check("usbWrite", 16'(usbWrite), 16'(m_write));
      check("usbData", usbData, m_data);
      check("overflow_flag", 16'(ovf), 16'(m_ovf));
      check("burstCount", burstCount, m_bursts);
      if (ack) n_ack++;
      if (usbWrite) begin
         n_wr++;
         wr_data.push_back(usbData);
      end
      if (ack && !ack_prev) ack_starts.push_back(cyc);
      ack_prev = ack;
      if (nw && nReset && !nReady) fifoData = fifoData + 10'd1;
   endtask

   initial begin
      m_left = 0; m_gap = 0; m_ovf = 1'b0; m_write = 1'b0; m_data = '0; m_bursts = '0;
      nReset = 1'b0; nReady = 1'b0; halfFull = 1'b1; full = 1'b1; usbReady = 1'b0;
      fifoData = '0;

      // Reset with flags asserted
      repeat (3) step();
      check("rst_ack", 16'(ack), 16'd0);
      check("rst_write", 16'(usbWrite), 16'd0);
      check("rst_data", usbData, 16'h0000);
      check("rst_ovf", 16'(ovf), 16'd0);
      check("rst_count", burstCount, 16'h0000);
      nReset = 1'b1; full = 1'b0; halfFull = 1'b0;
      step();
      check("idle_after_rst", 16'(ack), 16'd0);

      // Basic burst
      n_ack = 0; n_wr = 0; fifoData = '0;
      ack_starts.delete(); wr_data.delete();
      halfFull = 1'b1; usbReady = 1'b1;
      repeat (13) step();
      check("basic_acks", 16'(n_ack), 16'(BW));
      check("basic_writes", 16'(n_wr), 16'(BW));
      check("basic_count", burstCount, 16'd1);
      for (int i = 0; i < BW; i++) begin
         check("basic_word", (i < wr_data.size()) ? wr_data[i] : 16'hDEAD, 16'(i));
      end
      step();
      check("burst_spacing",
            (ack_starts.size() >= 2) ? 16'(ack_starts[1] - ack_starts[0]) : 16'hFFFF, 16'd13);
      halfFull = 1'b0; usbReady = 1'b0;
      repeat (14) step();

      // Gating on usbReady
      n_ack = 0;
      halfFull = 1'b1;
      repeat (5) step();
      check("gate_no_ack", 16'(n_ack), 16'd0);
      usbReady = 1'b1;
      step();
      check("gate_rise", 16'(ack), 16'd1);
      step();
      usbReady = 1'b0;
      repeat (12) step();
      check("gate_full_burst", 16'(n_ack), 16'(BW));

      // Overflow at word 3
      n_ack = 0; n_wr = 0;
      usbReady = 1'b1;
      repeat (4) step();
      full = 1'b1;
      step();
      check("ovf_ack_stop", 16'(ack), 16'd0);
      check("ovf_flag", 16'(ovf), 16'd1);
      full = 1'b0;
      repeat (10) step();
      check("ovf_acks", 16'(n_ack), 16'd4);
      check("ovf_writes", 16'(n_wr), 16'd4);
      check("ovf_sticky", 16'(ovf), 16'd1);
      nReady = 1'b1; usbReady = 1'b0;
      step();
      check("ovf_clear", 16'(ovf), 16'd0);
      nReady = 1'b0;
      step();
      check("ovf_idle", 16'(ack), 16'd0);

      // Abort at word 5
      save_b = m_bursts;
      n_ack = 0; n_wr = 0;
      usbReady = 1'b1;
      repeat (6) step();
      nReady = 1'b1;
      step();
      check("abort_ack", 16'(ack), 16'd0);
      check("abort_write", 16'(usbWrite), 16'd0);
      repeat (3) step();
      check("abort_acks", 16'(n_ack), 16'd6);
      check("abort_count", burstCount, save_b);
      nReady = 1'b0;
      step();
      check("abort_restart", 16'(ack), 16'd1);
      halfFull = 1'b0;
      repeat (12) step();
      check("abort_next_count", burstCount, save_b + 16'd1);

      // Counter wrap
      usbReady = 1'b0;
      repeat (6) step();
      force dut.burst_cnt_q = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.burst_cnt_q;
      m_bursts = 16'hFFFF;
      check("wrap_preload", burstCount, 16'hFFFF);
      halfFull = 1'b1; usbReady = 1'b1;
      step();
      halfFull = 1'b0;
      repeat (12) step();
      check("wrap_count", burstCount, 16'h0000);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         nReset   = ($urandom_range(0, 199) != 0);
         nReady   = ($urandom_range(0, 79) == 0);
         full     = ($urandom_range(0, 119) == 0);
         halfFull = ($urandom_range(0, 9) < 7);
         usbReady = ($urandom_range(0, 9) < 7);
         fifoData = 10'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the sample FIFO. Runs on the FIFO output clock, drains fixed-size bursts of 10-bit RF samples whenever the FIFO reports half-full, and presents them as 16-bit words with a write strobe toward the USB (FX3 slave-FIFO) interface. Also detects FIFO overflow, latches it, and halts transfer until the host de-asserts ready or resets.

## Interface
Parameters:
- BURST_WORDS, 2048: words per burst; legal range 1..4096, which guarantees the FIFO cannot run dry mid-burst once half-full is seen.
- GAP_CYCLES, 4: idle cycles after each burst, covering FX3 flag latency; legal range ≥1.

Ports:
- outputClock  in  1  sole clock (FIFO read clock); all logic on its rising edge.
- nReset  in  1  synchronous, active-low reset.
- nReady  in  1  host not-ready; 1 = abort/idle (the FIFO is cleared by the same signal).
- fifoData  in  10  FIFO show-ahead output word.
- halfFull_flag  in  1  registered FIFO level > 4096.
- full_flag  in  1  registered FIFO full.
- usbReady  in  1  FX3 can accept a full burst.
- outputAck  out  1  FIFO read acknowledge; consumes the current fifoData word.
- usbData  out  16  registered {6'b0, sample}.
- usbWrite  out  1  registered write strobe; usbData valid when 1.
- overflow_flag  out  1  sticky FIFO-overflow indicator.
- burstCount  out  16  completed-burst counter, wraps.

## Operation
- States: IDLE, BURST, GAP, OVERFLOW.
- Priority at every edge: nReset low > nReady high > full_flag high > normal transitions.
- nReset low: state IDLE; word and gap counters 0; usbData 0; usbWrite 0; overflow_flag 0; burstCount 0.
- nReady high (nReset high): state IDLE; counters 0; usbWrite 0; overflow_flag 0. usbData and burstCount are held.
- full_flag high (not reset or aborted), from IDLE, BURST or GAP: go to OVERFLOW and set overflow_flag.
- IDLE -> BURST when halfFull_flag && usbReady; word counter cleared.
- BURST: outputAck = 1 every cycle, combinational decode of the registered state. Each BURST cycle captures usbData <= {6'b0, fifoData} and usbWrite <= 1. The word counter increments.
- BURST: usbReady, halfFull_flag and empty are ignored.
- BURST -> GAP on the cycle the word counter equals BURST_WORDS-1. On that same edge, burstCount increments modulo 2^16.
- GAP: counts GAP_CYCLES cycles, then goes to IDLE.
- OVERFLOW: outputAck 0 and usbWrite 0. Exits only via nReady high or nReset low.
- outputAck is 0 in every state except BURST.
- usbWrite is 0 on any edge where the state is not BURST.

## Timing
- Entry: from the edge where IDLE sees halfFull_flag && usbReady, outputAck rises in the next cycle.
- usbWrite and usbData lag outputAck by exactly one cycle.
- A burst produces exactly BURST_WORDS consecutive outputAck cycles and exactly BURST_WORDS consecutive usbWrite cycles, with no bubbles.
- Minimum burst-to-burst spacing: BURST_WORDS + GAP_CYCLES + 1 cycles between first acks.
- full_flag during BURST: the ack in that cycle still completes, and its word is still written one cycle later. The next cycle has no ack, so at most one trailing usbWrite follows the transition.
- Abort via nReady mid-burst: no ack from the next cycle on; usbWrite 0 on the abort edge. The partial burst does not increment burstCount.
- burstCount 0xFFFF wraps to 0x0000.

## Test plan
- Reset: hold nReset low for 3 cycles with halfFull_flag=1 and full_flag=1. Require all outputs 0, and IDLE after release once full_flag=0.
- Basic burst: BURST_WORDS=8, GAP_CYCLES=4; halfFull_flag=1, usbReady=1, fifoData ramps 0x000..0x3FF. Require 8 acks, then 8 usbWrite cycles with usbData 0x0000+n matching the acked words, burstCount=1, and the next ack exactly 13 cycles after the first.
- Gating: halfFull_flag=1, usbReady=0 -> no ack. Raise usbReady -> ack next cycle. Drop usbReady mid-burst -> burst still completes all 8 words.
- Overflow: assert full_flag at burst word 3. Require ack stops the next cycle, 4 usbWrite pulses total, overflow_flag=1, and no further acks. Then pulse nReady=1 -> overflow_flag=0 and state IDLE.
- Abort: nReady=1 at word 5 -> no further acks or writes; burstCount unchanged; a new burst starts normally after nReady=0.
- Wrap: preload 65535 bursts (or force burstCount=0xFFFF), complete one burst -> burstCount=0x0000.
